// File: rtl/uni_sram_slave.sv
// rtl/uni_sram_slave.sv - fixed-latency single-port memory responder for the uni_if bus
module uni_sram_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1024,
    parameter int                LATENCY   = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              slv_valid,
    input  logic              slv_reqtyp,
    input  logic [ADDR_W-1:0] slv_addr,
    input  logic [DATA_W-1:0] slv_wdata,
    input  logic [1:0]        slv_size,
    input  logic              slv_cachable,
    output logic              slv_ready,
    output logic [DATA_W-1:0] slv_rdata
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam int              LANES    = DATA_W / 8;
    localparam logic [ADDR_W:0] SPAN     = (ADDR_W + 1)'(DEPTH * LANES);
    localparam logic [3:0]      CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              req_typ;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] dec_addr;
    logic              dec_typ;
    logic [ADDR_W-1:0] off;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        lane;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rsp_data;
    logic [15:0]       mask_wide;
    logic [LANES-1:0]  wmask;
    logic [DATA_W-1:0] wshift;
    logic              unused_bits;

    // In IDLE the decode looks at the live bus so LATENCY==1 can answer from the accepting edge;
    // afterwards only the latched copy matters.
    always_comb begin
        dec_addr  = (state == S_IDLE) ? slv_addr : req_addr;
        dec_typ   = (state == S_IDLE) ? slv_reqtyp : req_typ;
        off       = dec_addr - BASE_ADDR;
        in_range  = ({1'b0, off} < SPAN);
        idx       = off[IDX_W+2:3];
        lane      = dec_addr[2:0];
        rd_shift  = mem[idx] >> {lane, 3'b000};
        rsp_data  = (!dec_typ && in_range) ? rd_shift : '0;
        mask_wide = ((16'd1 << (4'd1 << req_size)) - 16'd1) << lane;
        wmask     = mask_wide[LANES-1:0];
        wshift    = req_wdata << {lane, 3'b000};
    end

    assign unused_bits = ^{slv_cachable, off[ADDR_W-1:IDX_W+3], off[2:0], mask_wide[15:LANES]};

    // Bytes shifted past lane 7 fall off the mask; misaligned writes never wrap into the next word.
    always_ff @(posedge i_clk) begin
        if (state == S_RESP && req_typ && in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (wmask[b]) begin
                    mem[idx][b*8 +: 8] <= wshift[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            req_typ   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_size  <= 2'b00;
            slv_ready <= 1'b0;
            slv_rdata <= '0;
        end else begin
            slv_ready <= 1'b0;
            slv_rdata <= '0;
            case (state)
                S_IDLE: begin
                    if (slv_valid) begin
                        req_typ   <= slv_reqtyp;
                        req_addr  <= slv_addr;
                        req_wdata <= slv_wdata;
                        req_size  <= slv_size;
                        if (LATENCY == 1) begin
                            state     <= S_RESP;
                            slv_ready <= 1'b1;
                            slv_rdata <= rsp_data;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= S_RESP;
                        slv_ready <= 1'b1;
                        slv_rdata <= rsp_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uni_sram_slave.sv
// tb/tb_uni_sram_slave.sv - self-checking bench for uni_sram_slave (LATENCY 2 and 4 instances)
module tb_uni_sram_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst4_n;
    logic        v    [2];
    logic        typ  [2];
    logic        cach [2];
    logic [31:0] addr [2];
    logic [63:0] wd   [2];
    logic [1:0]  sz   [2];
    logic        rdy  [2];
    logic [63:0] rdt  [2];

    int total = 0;
    int bad   = 0;

    logic [63:0] mm [WORDS];

    always #5 clk = ~clk;

    uni_sram_slave #(.LATENCY(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .slv_valid(v[0]), .slv_reqtyp(typ[0]), .slv_addr(addr[0]), .slv_wdata(wd[0]),
        .slv_size(sz[0]), .slv_cachable(cach[0]), .slv_ready(rdy[0]), .slv_rdata(rdt[0])
    );

    uni_sram_slave #(.LATENCY(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst4_n),
        .slv_valid(v[1]), .slv_reqtyp(typ[1]), .slv_addr(addr[1]), .slv_wdata(wd[1]),
        .slv_size(sz[1]), .slv_cachable(cach[1]), .slv_ready(rdy[1]), .slv_rdata(rdt[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (o >= 32'(WORDS * 8)) return 64'd0;
        return mm[o[12:3]] >> (8 * int'(a[2:0]));
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        logic [31:0] o;
        int          p;
        o = a - BASE;
        if (o < 32'(WORDS * 8)) begin
            for (int b = 0; b < (1 << s); b++) begin
                p = int'(a[2:0]) + b;
                if (p < 8) mm[o[12:3]][8*p +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // Caller enters 1 time unit after a rising edge with the target instance idle.
    task automatic xact(input int u, input logic t, input logic [31:0] a, input logic [63:0] d,
                        input logic [1:0] s, output logic [63:0] rd, output int lat);
        v[u] = 1'b1; typ[u] = t; addr[u] = a; wd[u] = d; sz[u] = s; cach[u] = 1'($urandom);
        @(posedge clk); #1;
        lat = 1;
        typ[u] = 1'($urandom); addr[u] = $urandom; wd[u] = {$urandom, $urandom}; sz[u] = 2'($urandom);
        while (rdy[u] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdt[u];
        v[u] = 1'b0;
        @(posedge clk); #1;
        chk("ready_one_cycle", 64'(rdy[u]), 64'd0);
    endtask

    task automatic do_wr(input int u, input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        logic [63:0] rd;
        int          lat;
        xact(u, 1'b1, a, d, s, rd, lat);
        chk("wr_latency", 64'(lat), (u == 0) ? 64'd2 : 64'd4);
        chk("wr_rdata_zero", rd, 64'd0);
        if (u == 0) m_write(a, d, s);
    endtask

    task automatic do_rd(input int u, input logic [31:0] a, input logic [1:0] s, output logic [63:0] rd);
        int lat;
        xact(u, 1'b0, a, {$urandom, $urandom}, s, rd, lat);
        chk("rd_latency", 64'(lat), (u == 0) ? 64'd2 : 64'd4);
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] a;
        int          npulse;
        int          last;

        for (int u = 0; u < 2; u++) begin
            v[u] = 1'b0; typ[u] = 1'b0; cach[u] = 1'b0; addr[u] = '0; wd[u] = '0; sz[u] = '0;
        end
        rst_n = 1'b0; rst4_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("reset_ready", 64'(rdy[u]), 64'd0);
            chk("reset_rdata", rdt[u], 64'd0);
        end
        rst_n = 1'b1; rst4_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < WORDS; i++) do_wr(0, BASE + 32'(i * 8), {$urandom, $urandom}, 2'b11);

        do_wr(0, 32'h8000_0010, 64'h1122_3344_5566_7788, 2'b11);
        do_rd(0, 32'h8000_0010, 2'b11, r);
        chk("dword_readback", r, 64'h1122_3344_5566_7788);

        do_wr(0, 32'h8000_0010, 64'd0, 2'b11);
        do_wr(0, 32'h8000_0013, 64'h0000_0000_0000_00AA, 2'b00);
        do_rd(0, 32'h8000_0010, 2'b11, r);
        chk("sb_lane3", r, 64'h0000_0000_AA00_0000);
        do_wr(0, 32'h8000_0016, 64'h0000_0000_0000_BEEF, 2'b01);
        do_rd(0, 32'h8000_0010, 2'b11, r);
        chk("sh_lane6", r, 64'hBEEF_0000_AA00_0000);

        do_rd(0, 32'h8000_0014, 2'b10, r);
        chk("lane_read", r, 64'h0000_0000_BEEF_0000);

        do_wr(0, 32'h8000_0020, 64'd0, 2'b11);
        do_wr(0, 32'h8000_0028, 64'h0123_4567_89AB_CDEF, 2'b11);
        do_wr(0, 32'h8000_0025, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
        do_rd(0, 32'h8000_0020, 2'b11, r);
        chk("misaligned_word", r, 64'hFFFF_FF00_0000_0000);
        do_rd(0, 32'h8000_0028, 2'b11, r);
        chk("misaligned_next", r, 64'h0123_4567_89AB_CDEF);

        do_rd(0, 32'h7FFF_FFF8, 2'b11, r);
        chk("oor_below", r, 64'd0);
        do_rd(0, BASE + 32'(WORDS * 8), 2'b11, r);
        chk("oor_above", r, 64'd0);
        do_wr(0, BASE + 32'(WORDS * 8), 64'hDEAD_BEEF_DEAD_BEEF, 2'b11);
        do_wr(0, 32'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 2'b11);

        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, WORDS * 8 - 1));
            if ($urandom_range(0, 1) == 1) begin
                do_wr(0, a, {$urandom, $urandom}, 2'($urandom));
            end else begin
                do_rd(0, a, 2'($urandom), r);
                chk("random_read", r, m_read(a));
            end
        end

        for (int i = 0; i < WORDS; i++) begin
            do_rd(0, BASE + 32'(i * 8), 2'b11, r);
            chk("array_readback", r, mm[i]);
        end

        do_wr(1, 32'h8000_0100, 64'hCAFE_F00D_1234_5678, 2'b11);
        v[1] = 1'b1; typ[1] = 1'b1; addr[1] = 32'h8000_0100; wd[1] = 64'd0; sz[1] = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4_n = 1'b0;
        #1;
        chk("rst_mid_ready", 64'(rdy[1]), 64'd0);
        chk("rst_mid_rdata", rdt[1], 64'd0);
        npulse = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy[1] === 1'b1) npulse++;
        end
        v[1] = 1'b0;
        rst4_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdy[1] === 1'b1) npulse++;
        end
        chk("rst_no_ready", 64'(npulse), 64'd0);
        do_rd(1, 32'h8000_0100, 2'b11, r);
        chk("rst_word_kept", r, 64'hCAFE_F00D_1234_5678);

        v[1] = 1'b1; typ[1] = 1'b0; addr[1] = 32'h8000_0100; sz[1] = 2'b11;
        npulse = 0; last = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (rdy[1] === 1'b1) begin
                npulse++;
                if (last < 0) chk("b2b_first", 64'(n), 64'd4);
                else chk("b2b_interval", 64'(n - last), 64'd5);
                chk("b2b_rdata", rdt[1], 64'hCAFE_F00D_1234_5678);
                last = n;
            end
        end
        v[1] = 1'b0;
        chk("b2b_count", 64'(npulse), 64'd4);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
